dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Word-addressed data-memory responder: the target end of the core's load/store request/response interface.
- Accepts one request at a time over a valid/ready request channel and performs the read or byte-masked write after a fixed latency.
- Returns read data or an error flag over a valid/ready response channel.
- Sits between the core's memory stage and on-chip SRAM and stands in for the data memory in simulation.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, >= 2.
- LATENCY, 2, cycles from request acceptance to rsp_valid assertion; integer >= 1.

Ports:
- clk  input  1  clock, all state on rising edge
- rstn  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = write, 0 = read
- req_addr  input  32  byte address
- req_wdata  input  32  write data
- req_be  input  4  byte enables; bit i covers wdata[8i+7:8i]
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts the response
- rsp_rdata  output  32  read data; 0 for writes and errors
- rsp_err  output  1  request was misaligned or out of range

Behaviour:
- Reset (rstn low, asynchronous): FSM goes to IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Memory array is not reset; contents are undefined until written.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1.
  - On req_valid & req_ready, latch we/addr/wdata/be.
  - Then go to WAIT with count=LATENCY-1, or directly to RESP when LATENCY==1.
- WAIT:
  - req_ready=0; count decrements each cycle.
  - At count==0, the next edge moves to RESP and performs the access.
- Access, performed on the edge that enters RESP:
  - err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS).
  - Read, no error: rsp_rdata = mem[addr[31:2]]; a read returns the full word regardless of be.
  - Write, no error: mem bytes with be[i]=1 are updated; rsp_rdata=0.
  - be=4'b0000 on a write is a legal no-op with err=0.
  - Error: no memory update, rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - req_ready=0.
  - On rsp_valid & rsp_ready, the next edge returns to IDLE with rsp_valid=0, rsp_rdata=0 and rsp_err=0.
- Latency: request accepted at edge T; rsp_valid is high from edge T+LATENCY. Earliest next acceptance is the edge after the response handshake, giving one outstanding request.
- req_valid is ignored outside IDLE; the requester must hold the request until req_ready.
- A request present at the same time as rsp_ready in RESP is not accepted that cycle.
- Reset asserted mid-transaction drops the transaction. A pending write that has not reached the RESP edge is not committed.
- Address bits above the word index are only used for the range check; there is no wrap-around.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- When defined, two extra output ports exist:
  - rd_count (32): completed read responses.
  - wr_count (32): completed write responses.
  - Both reset to 0 and increment on the response handshake only when rsp_err=0.
  - Both wrap from 0xFFFFFFFF to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Write-then-read, LATENCY=2: write addr=0x10, wdata=0xDEADBEEF, be=4'hF, rsp_ready=1. rsp_valid rises 2 cycles after acceptance with rdata=0, err=0. A read of 0x10 returns 0xDEADBEEF.
- Byte enables: after storing 0xDEADBEEF at 0x10, write wdata=0x11223344 with be=4'b0101. A read of 0x10 returns 0xDE22BE44.
- Errors:
  - Read addr=0x12 returns err=1, rdata=0.
  - Write to addr=DEPTH_WORDS*4 returns err=1, and a read of word 0 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid, rdata and err stay stable.
  - req_ready stays 0, and a second req_valid is not accepted until the cycle after the handshake.
- Reset mid-WAIT: issue write 0xCAFEF00D to 0x20 (previously 0x0) and assert rstn=0 during WAIT.
  - Outputs return to their reset values immediately.
  - A subsequent read of 0x20 returns 0x00000000.
- With DMEM_PERF_CNT_EN defined: 3 good reads, 2 good writes and 1 error give rd_count=3 and wr_count=2.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with valid/ready request and response channels.
// Optional macro DMEM_PERF_CNT_EN adds rd_count/wr_count completed-response counters.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
`ifdef DMEM_PERF_CNT_EN
   ,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
`endif
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   logic          lat_we;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic [3:0]    lat_be;

   logic [31:0]   mem [DEPTH_WORDS];

   logic          accept;
   logic          access;
   logic          acc_we;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_be;
   logic          acc_err;
   logic [AW-1:0] acc_idx;
   logic [31:0]   acc_rdata;

   // With LATENCY==1 the access happens on the accepting edge, so it must use the live request.
   always_comb begin
      accept = (state == IDLE) && req_valid;
      if (LATENCY == 1) begin
         access = accept;
      end else begin
         access = (state == WAIT) && (cnt == '0);
      end
      acc_we    = (state == IDLE) ? req_we    : lat_we;
      acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
      acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
      acc_be    = (state == IDLE) ? req_be    : lat_be;
      acc_err   = (acc_addr[1:0] != 2'b00) ||
                  ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
      acc_idx   = acc_addr[AW+1:2];
      acc_rdata = (acc_we || acc_err) ? 32'h0 : mem[acc_idx];
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lat_we    <= req_we;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
         lat_be    <= req_be;
      end
   end

   // Writes commit only on the edge entering RESP; a reset before then drops them.
   always_ff @(posedge clk) begin
      if (access && acc_we && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) begin
               mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
`ifdef DMEM_PERF_CNT_EN
         rd_count  <= 32'h0;
         wr_count  <= 32'h0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  req_ready <= 1'b0;
                  if (LATENCY == 1) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= acc_rdata;
                     rsp_err   <= acc_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= CW'(LATENCY - 1);
                  end
               end
            end
            WAIT: begin
               if (access) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= acc_rdata;
                  rsp_err   <= acc_err;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= 32'h0;
                  rsp_err   <= 1'b0;
`ifdef DMEM_PERF_CNT_EN
                  if (!rsp_err) begin
                     if (lat_we) begin
                        wr_count <= wr_count + 32'h1;
                     end else begin
                        rd_count <= rd_count + 32'h1;
                     end
                  end
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: predictions queued at request time, checked at response.
module tb_dmem_responder;

   localparam int DEPTH_WORDS = 1024;
   localparam int LATENCY     = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [3:0]  req_be = 4'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
`ifdef DMEM_PERF_CNT_EN
   logic [31:0] rd_count;
   logic [31:0] wr_count;
`endif

   int rd_exp = 0;
   int wr_exp = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        we;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [int];

   dmem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
`ifdef DMEM_PERF_CNT_EN
      .rd_count  (rd_count),
      .wr_count  (wr_count),
`endif
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Sets request fields (valid untouched) and, if tracked, queues the predicted response.
   task automatic stage_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input bit track);
      exp_t        e;
      int          k;
      logic [31:0] w;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      if (track) begin
         k       = int'(addr >> 2);
         e.we    = we;
         e.err   = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH_WORDS));
         e.rdata = 32'h0;
         if (!e.err) begin
            w = model.exists(k) ? model[k] : 32'h0;
            if (we) begin
               for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
               model[k] = w;
            end else begin
               e.rdata = w;
            end
         end
         sb.push_back(e);
      end
   endtask

   task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input bit track);
      int n = 0;
      stage_req(we, addr, wdata, be, track);
      req_valid = 1'b1;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check_eq("req_ready_timeout", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Waits for the response, compares it, optionally stalls, then completes the handshake.
   task automatic collect(input int hold, input bit pend_next);
      exp_t e;
      int   n = 0;
      rsp_ready = (hold == 0);
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 50);
      check_eq("rsp_valid_seen", 32'(rsp_valid), 32'd1);
      if (!rsp_valid) begin
         rsp_ready = 1'b1;
         return;
      end
      check_eq("latency_cycles", 32'(n), 32'(LATENCY + 1));
      if (sb.size() == 0) begin
         check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      check_eq("rdata", rsp_rdata, e.rdata);
      check_eq("err", 32'(rsp_err), 32'(e.err));
      if (pend_next) req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq("stall_valid", 32'(rsp_valid), 32'd1);
         check_eq("stall_rdata", rsp_rdata, e.rdata);
         check_eq("stall_err", 32'(rsp_err), 32'(e.err));
         check_eq("stall_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      if (!e.err) begin
         if (e.we) wr_exp++;
         else rd_exp++;
      end
      @(negedge clk);
      check_eq("post_valid", 32'(rsp_valid), 32'd0);
      check_eq("post_rdata", rsp_rdata, 32'h0);
      check_eq("post_err", 32'(rsp_err), 32'd0);
      check_eq("post_req_ready", 32'(req_ready), 32'd1);
   endtask

   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be);
      drive_req(we, addr, wdata, be, 1'b1);
      collect(0, 1'b0);
   endtask

   initial begin
      #2 rstn = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_req_ready", 32'(req_ready), 32'd1);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_rdata", rsp_rdata, 32'h0);
      check_eq("rst_err", 32'(rsp_err), 32'd0);
`ifdef DMEM_PERF_CNT_EN
      check_eq("rst_rd_count", rd_count, 32'h0);
      check_eq("rst_wr_count", wr_count, 32'h0);
`endif
      rstn = 1'b1;
      @(negedge clk);

      txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      txn(1'b0, 32'h10, 32'h0, 4'hF);
      txn(1'b1, 32'h10, 32'h11223344, 4'b0101);
      txn(1'b0, 32'h10, 32'h0, 4'h0);
      if (model[4] !== 32'hDE22BE44) check_eq("model_be", model[4], 32'hDE22BE44);

      txn(1'b1, 32'h0, 32'hA5A55A5A, 4'hF);
      txn(1'b0, 32'h12, 32'h0, 4'hF);
      txn(1'b1, 32'(DEPTH_WORDS * 4), 32'h12345678, 4'hF);
      txn(1'b0, 32'h0, 32'h0, 4'hF);
      txn(1'b1, 32'h80000010, 32'h77777777, 4'hF);
      txn(1'b0, 32'h10, 32'h0, 4'hF);
      txn(1'b1, 32'(DEPTH_WORDS * 4 - 4), 32'h0BADF00D, 4'hF);
      txn(1'b0, 32'(DEPTH_WORDS * 4 - 4), 32'h0, 4'hF);
      txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
      txn(1'b0, 32'h10, 32'h0, 4'hF);

      // Backpressure with a second request waiting in the wings.
      drive_req(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
      stage_req(1'b0, 32'h0, 32'h0, 4'hF, 1'b1);
      collect(5, 1'b1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      collect(0, 1'b0);

      for (int i = 0; i < 8; i++) txn(1'b1, 32'h40 + 32'(4 * i), $urandom, 4'hF);
      for (int i = 0; i < 16; i++) begin
         txn(1'($urandom_range(0, 1)), 32'h40 + 32'($urandom_range(0, 31)),
             $urandom, 4'($urandom_range(0, 15)));
      end

      // Reset mid-WAIT drops a pending write.
      txn(1'b1, 32'h20, 32'h0, 4'hF);
      drive_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check_eq("midrst_req_ready", 32'(req_ready), 32'd1);
      check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("midrst_rdata", rsp_rdata, 32'h0);
      check_eq("midrst_err", 32'(rsp_err), 32'd0);
      rd_exp = 0;
      wr_exp = 0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      txn(1'b0, 32'h20, 32'h0, 4'hF);
      txn(1'b1, 32'h24, 32'h01020304, 4'hF);
      txn(1'b1, 32'h28, 32'h05060708, 4'hF);
      txn(1'b0, 32'h24, 32'h0, 4'hF);
      txn(1'b0, 32'h28, 32'h0, 4'hF);
      txn(1'b0, 32'h13, 32'h0, 4'hF);
`ifdef DMEM_PERF_CNT_EN
      check_eq("rd_count", rd_count, 32'd3);
      check_eq("wr_count", wr_count, 32'd2);
      check_eq("rd_count_model", rd_count, 32'(rd_exp));
      check_eq("wr_count_model", wr_count, 32'(wr_exp));
`endif
      check_eq("sb_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
